// File: rtl/demux_buf_d.sv
// Registered 1-to-4 distributor: steers one WIDTH-bit word per cycle into one of
// four depth-1 channel buffers selected by {s1, s0}, each with a valid/ready handshake.
module demux_buf_d #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             s0,
    input  logic             s1,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [3:0]       acc_count
);

    // Handshake: a word moves on a port in any cycle where its valid and ready are
    // both high at the rising edge. in_ready never looks at in_valid, so the
    // producer may compute in_valid from in_ready without forming a loop.

    logic [1:0]       sel;
    logic [3:0]       drain;
    logic             acc;

    logic [WIDTH-1:0] data_q [4];
    logic [WIDTH-1:0] data_d [4];
    logic [3:0]       valid_q;
    logic [3:0]       valid_d;
    logic [3:0]       count_q;
    logic [3:0]       count_d;

    assign sel      = {s1, s0};
    assign drain    = valid_q & out_ready;
    // A full channel that empties this cycle can take the new word in the same edge.
    assign in_ready = ~valid_q[sel] | drain[sel];
    assign acc      = in_valid & in_ready;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        count_d = count_q;
        for (int n = 0; n < 4; n++) begin
            if (drain[n]) begin
                valid_d[n] = 1'b0;
            end
        end
        // Accept overrides a same-cycle drain on the selected channel.
        if (acc) begin
            data_d[sel]  = in;
            valid_d[sel] = 1'b1;
            count_d      = count_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int n = 0; n < 4; n++) begin
                data_q[n] <= '0;
            end
            valid_q <= 4'b0000;
            count_q <= 4'd0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                data_q[n] <= data_d[n];
            end
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign out0      = data_q[0];
    assign out1      = data_q[1];
    assign out2      = data_q[2];
    assign out3      = data_q[3];
    assign out_valid = valid_q;
    assign acc_count = count_q;

endmodule

// File: tb/tb_demux_buf_d.sv
// Directed bench for demux_buf_d: hand-computed expectations for fill, back-pressure,
// same-cycle drain/accept, streaming with counter wrap, and asynchronous reset.
module tb_demux_buf_d;

  localparam int WIDTH = 4;

  logic             clk;
  logic             n_reset;
  logic             s0;
  logic             s1;
  logic [WIDTH-1:0] in_w;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [3:0]       acc_count;

  int n_checks;
  int n_fails;

  demux_buf_d #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .s0        (s0),
    .s1        (s1),
    .in        (in_w),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_count (acc_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [3:0] data,
                       input logic [3:0] rdy);
    in_valid  = v;
    s1        = sel[1];
    s0        = sel[0];
    in_w      = data;
    out_ready = rdy;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                            input logic [3:0] e2, input logic [3:0] e3,
                            input logic [3:0] ev, input logic [3:0] ec);
    check({tag, ".out0"}, 32'(out0), 32'(e0));
    check({tag, ".out1"}, 32'(out1), 32'(e1));
    check({tag, ".out2"}, 32'(out2), 32'(e2));
    check({tag, ".out3"}, 32'(out3), 32'(e3));
    check({tag, ".valid"}, 32'(out_valid), 32'(ev));
    check({tag, ".count"}, 32'(acc_count), 32'(ec));
  endtask

  logic [3:0] fill_data [4];
  logic [3:0] w;

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    n_reset   = 1'b0;
    drive(1'b0, 2'b00, 4'h0, 4'b0000);
    fill_data[0] = 4'b0001;
    fill_data[1] = 4'b1010;
    fill_data[2] = 4'b1100;
    fill_data[3] = 4'b1111;

    // reset state, in_ready high for every select
    #3;
    check_outs("reset", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 4'd0);
    for (int s = 0; s < 4; s++) begin
      drive(1'b0, 2'(s), 4'h0, 4'b0000);
      #1;
      check($sformatf("reset.in_ready%0d", s), 32'(in_ready), 32'd1);
    end
    step();
    n_reset = 1'b1;

    // fill all four channels on consecutive edges
    for (int s = 0; s < 4; s++) begin
      drive(1'b1, 2'(s), fill_data[s], 4'b0000);
      #1;
      check($sformatf("fill.in_ready%0d", s), 32'(in_ready), 32'd1);
      step();
    end
    drive(1'b0, 2'b00, 4'h0, 4'b0000);
    check_outs("fill", 4'b0001, 4'b1010, 4'b1100, 4'b1111, 4'b1111, 4'd4);

    // back-pressure: ch1 full, no drain
    drive(1'b1, 2'b01, 4'b0110, 4'b0000);
    #1;
    check("bp.in_ready", 32'(in_ready), 32'd0);
    step();
    check_outs("bp", 4'b0001, 4'b1010, 4'b1100, 4'b1111, 4'b1111, 4'd4);

    // same-cycle drain and accept on ch1
    drive(1'b1, 2'b01, 4'b0110, 4'b0010);
    #1;
    check("pass.in_ready", 32'(in_ready), 32'd1);
    step();
    drive(1'b0, 2'b00, 4'h0, 4'b0000);
    check_outs("pass", 4'b0001, 4'b0110, 4'b1100, 4'b1111, 4'b1111, 4'd5);

    // drain ch0, ch1, ch3 with no input; data must persist
    drive(1'b0, 2'b11, 4'h9, 4'b1011);
    step();
    drive(1'b0, 2'b00, 4'h0, 4'b0000);
    check_outs("drain", 4'b0001, 4'b0110, 4'b1100, 4'b1111, 4'b0100, 4'd5);

    // out_ready on an empty channel does nothing
    drive(1'b0, 2'b00, 4'h0, 4'b0001);
    step();
    check_outs("idle_rdy", 4'b0001, 4'b0110, 4'b1100, 4'b1111, 4'b0100, 4'd5);

    // drain ch2 while accepting into ch0
    drive(1'b1, 2'b00, 4'b0011, 4'b0100);
    #1;
    check("split.in_ready", 32'(in_ready), 32'd1);
    step();
    drive(1'b0, 2'b00, 4'h0, 4'b0000);
    check_outs("split", 4'b0011, 4'b0110, 4'b1100, 4'b1111, 4'b0001, 4'd6);

    // stream 17 words to ch3 from a fresh reset; counter wraps 15 -> 0 -> 1
    n_reset = 1'b0;
    #1;
    n_reset = 1'b1;
    for (int i = 0; i < 17; i++) begin
      w = 4'((i * 3 + 1) % 16);
      drive(1'b1, 2'b11, w, 4'b1000);
      #1;
      check($sformatf("stream%0d.in_ready", i), 32'(in_ready), 32'd1);
      step();
      check($sformatf("stream%0d.out3", i), 32'(out3), 32'(w));
      check($sformatf("stream%0d.valid", i), 32'(out_valid), 32'b1000);
      check($sformatf("stream%0d.count", i), 32'(acc_count), 32'((i + 1) % 16));
    end
    drive(1'b0, 2'b00, 4'h0, 4'b0000);
    check("stream.final_count", 32'(acc_count), 32'd1);

    // drain ch3, then load ch0, ch1, ch3 and reset asynchronously mid-cycle
    drive(1'b0, 2'b00, 4'h0, 4'b1000);
    step();
    drive(1'b1, 2'b00, 4'b0101, 4'b0000);
    step();
    drive(1'b1, 2'b01, 4'b0110, 4'b0000);
    step();
    drive(1'b1, 2'b11, 4'b0111, 4'b0000);
    step();
    check_outs("pre_rst", 4'b0101, 4'b0110, 4'h0, 4'b0111, 4'b1011, 4'd4);
    drive(1'b1, 2'b10, 4'b1001, 4'b0000);
    #2;
    n_reset = 1'b0;
    #1;
    check_outs("async_rst", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 4'd0);
    check("async_rst.in_ready", 32'(in_ready), 32'd1);
    step();
    check_outs("rst_hold", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 4'd0);
    drive(1'b0, 2'b00, 4'h0, 4'b0000);
    n_reset = 1'b1;

    // first accept straight after reset release
    drive(1'b1, 2'b10, 4'b1001, 4'b0000);
    step();
    drive(1'b0, 2'b00, 4'h0, 4'b0000);
    check_outs("post_rst", 4'h0, 4'h0, 4'b1001, 4'h0, 4'b0100, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
